// File: rtl/grf_wb_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter and its MDU result buffer.
package grf_wb_arbiter_pkg;
  localparam int GRF_ADDR_W = 5;
  localparam int GRF_DATA_W = 32;

  typedef struct packed {
    logic                  live;
    logic [GRF_ADDR_W-1:0] addr;
    logic [GRF_DATA_W-1:0] data;
    logic [GRF_DATA_W-1:0] pc;
  } wb_entry_t;
endpackage

// File: rtl/grf_wb_fifo.sv
// MDU result buffer: in-order FIFO with an address-match kill CAM and two read-match ports.
// Freed and reset slots are always dead, so the match logic can scan every slot.
module grf_wb_fifo
  import grf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enq,
  input  logic [GRF_ADDR_W-1:0] enq_addr,
  input  logic [GRF_DATA_W-1:0] enq_data,
  input  logic [GRF_DATA_W-1:0] enq_pc,
  input  logic                  pop,
  input  logic                  kill,
  input  logic [GRF_ADDR_W-1:0] kill_addr,
  output logic                  full,
  output logic                  empty,
  output wb_entry_t             head,
  output logic [31:0]           pending_mask,
  input  logic [GRF_ADDR_W-1:0] rd_addr1,
  input  logic [GRF_ADDR_W-1:0] rd_addr2,
  output logic                  rd_hit1,
  output logic                  rd_hit2,
  output logic [GRF_DATA_W-1:0] rd_data1,
  output logic [GRF_DATA_W-1:0] rd_data2
);
  localparam int AW = $clog2(DEPTH);

  wb_entry_t      mem [DEPTH];
  logic [AW:0]    wptr;
  logic [AW:0]    rptr;
  logic           push;
  logic           enq_live;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head  = mem[rptr[AW-1:0]];
  assign push  = enq && !full;
  // A same-cycle pipeline write to the same register is younger than the MDU result.
  assign enq_live = (enq_addr != '0) && !(kill && (kill_addr == enq_addr));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i].live <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (mem[i].live && ((kill && (mem[i].addr == kill_addr)) ||
                            (push && enq_live && (mem[i].addr == enq_addr))))
          mem[i].live <= 1'b0;
      end
      if (pop) begin
        mem[rptr[AW-1:0]].live <= 1'b0;
        rptr <= rptr + 1'b1;
      end
      if (push) begin
        mem[wptr[AW-1:0]] <= '{live: enq_live, addr: enq_addr, data: enq_data, pc: enq_pc};
        wptr <= wptr + 1'b1;
      end
    end
  end

  // At most one live entry per address, so OR-merging matched data is exact.
  always_comb begin
    pending_mask = '0;
    rd_hit1      = 1'b0;
    rd_hit2      = 1'b0;
    rd_data1     = '0;
    rd_data2     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem[i].live) begin
        pending_mask[mem[i].addr] = 1'b1;
        if ((rd_addr1 != '0) && (mem[i].addr == rd_addr1)) begin
          rd_hit1  = 1'b1;
          rd_data1 = rd_data1 | mem[i].data;
        end
        if ((rd_addr2 != '0) && (mem[i].addr == rd_addr2)) begin
          rd_hit2  = 1'b1;
          rd_data2 = rd_data2 | mem[i].data;
        end
      end
    end
    pending_mask[0] = 1'b0;
  end
endmodule

// File: rtl/grf_wb_arbiter.sv
// Register-file write port arbiter: pipeline has priority, buffered MDU results drain into idle
// cycles, and a starved live head forces a one-cycle pipeline stall.
module grf_wb_arbiter
  import grf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [GRF_ADDR_W-1:0] pipe_waddr,
  input  logic [GRF_DATA_W-1:0] pipe_wdata,
  input  logic [GRF_DATA_W-1:0] pipe_pc,
  output logic                  pipe_stall,
  input  logic                  mdu_valid,
  output logic                  mdu_ready,
  input  logic [GRF_ADDR_W-1:0] mdu_waddr,
  input  logic [GRF_DATA_W-1:0] mdu_wdata,
  input  logic [GRF_DATA_W-1:0] mdu_pc,
  output logic [GRF_ADDR_W-1:0] grf_waddr,
  output logic [GRF_DATA_W-1:0] grf_wdata,
  output logic [GRF_DATA_W-1:0] grf_pc,
  output logic [31:0]           pending_mask,
  input  logic [GRF_ADDR_W-1:0] rd_addr1,
  input  logic [GRF_ADDR_W-1:0] rd_addr2,
  output logic                  rd_hit1,
  output logic                  rd_hit2,
  output logic [GRF_DATA_W-1:0] rd_data1,
  output logic [GRF_DATA_W-1:0] rd_data2
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  wb_entry_t             head;
  logic                  full;
  logic                  empty;
  logic                  head_live;
  logic                  stall_int;
  logic                  pipe_win;
  logic                  head_wr;
  logic                  pop;
  logic                  enq;
  logic [CW-1:0]         starve_cnt;
  logic [31:0]           f_mask;
  logic                  f_hit1;
  logic                  f_hit2;
  logic [GRF_DATA_W-1:0] f_data1;
  logic [GRF_DATA_W-1:0] f_data2;

  assign head_live = !empty && head.live;
  assign stall_int = (starve_cnt == CW'(STARVE_LIMIT)) && head_live;
  assign pipe_win  = resetn && !stall_int && (pipe_waddr != '0);
  assign head_wr   = resetn && head_live && (stall_int || (pipe_waddr == '0));
  // Dead heads leave without touching the port.
  assign pop       = resetn && !empty && (!head.live || head_wr);
  assign mdu_ready = resetn && !full;
  assign enq       = mdu_valid && mdu_ready;
  assign pipe_stall = resetn && stall_int;

  grf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .resetn       (resetn),
    .enq          (enq),
    .enq_addr     (mdu_waddr),
    .enq_data     (mdu_wdata),
    .enq_pc       (mdu_pc),
    .pop          (pop),
    .kill         (pipe_win),
    .kill_addr    (pipe_waddr),
    .full         (full),
    .empty        (empty),
    .head         (head),
    .pending_mask (f_mask),
    .rd_addr1     (rd_addr1),
    .rd_addr2     (rd_addr2),
    .rd_hit1      (f_hit1),
    .rd_hit2      (f_hit2),
    .rd_data1     (f_data1),
    .rd_data2     (f_data2)
  );

  always_comb begin
    grf_waddr = '0;
    grf_wdata = '0;
    grf_pc    = '0;
    if (head_wr) begin
      grf_waddr = head.addr;
      grf_wdata = head.data;
      grf_pc    = head.pc;
    end else if (pipe_win) begin
      grf_waddr = pipe_waddr;
      grf_wdata = pipe_wdata;
      grf_pc    = pipe_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (head_wr || empty) begin
      starve_cnt <= '0;
    end else if (head_live && pipe_win && (starve_cnt != CW'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign pending_mask = resetn ? f_mask : '0;
  assign rd_hit1      = resetn && f_hit1;
  assign rd_hit2      = resetn && f_hit2;
  assign rd_data1     = resetn ? f_data1 : '0;
  assign rd_data2     = resetn ? f_data2 : '0;
endmodule
